// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, issues in-order imem requests,
// buffers responses in a small fetch queue and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QDEPTH      = 2,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_D,
    output logic [31:0] instruction_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc_q;
    logic        run_q;
    cnt_t        inflight_q;
    cnt_t        drop_cnt_q;
    cnt_t        q_count_q;
    ptr_t        q_head_q;
    ptr_t        q_tail_q;
    ptr_t        tag_head_q;
    ptr_t        tag_tail_q;

    logic [31:0] q_pc_q   [QDEPTH];
    logic [31:0] q_data_q [QDEPTH];
    logic [31:0] tag_q    [QDEPTH];

    logic [31:0] instr_q;
    logic [31:0] pc_d_q;
    logic        valid_q;

    logic [CW:0] occupancy;
    logic        issue;
    logic        rsp_keep;
    logic        pop;
    logic        unused_rpc_bits;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queue entries and in-flight requests share one credit pool, so the queue never overflows.
    assign occupancy      = {1'b0, q_count_q} + {1'b0, inflight_q};
    assign imem_req_valid = run_q && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign pop            = !redirect_valid && !stall_D && (q_count_q != '0);

    assign instruction_D   = instr_q;
    assign pc_D            = pc_d_q;
    assign pc_plus4_D      = pc_d_q + 32'd4;
    assign valid_D         = valid_q;
    assign unused_rpc_bits = ^redirect_pc[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            q_count_q  <= '0;
            q_head_q   <= '0;
            q_tail_q   <= '0;
            tag_head_q <= '0;
            tag_tail_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                // Everything still outstanding belongs to the squashed path.
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                inflight_q <= inflight_q - cnt_t'(imem_rsp_valid);
                drop_cnt_q <= inflight_q - cnt_t'(imem_rsp_valid);
                q_count_q  <= '0;
                q_head_q   <= '0;
                q_tail_q   <= '0;
                tag_head_q <= '0;
                tag_tail_q <= '0;
            end else begin
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                    tag_tail_q <= ptr_inc(tag_tail_q);
                end
                inflight_q <= inflight_q + cnt_t'(issue) - cnt_t'(imem_rsp_valid);
                if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - 1'b1;
                end
                if (rsp_keep) begin
                    tag_head_q <= ptr_inc(tag_head_q);
                    q_tail_q   <= ptr_inc(q_tail_q);
                end
                if (pop) begin
                    q_head_q <= ptr_inc(q_head_q);
                end
                q_count_q <= q_count_q + cnt_t'(rsp_keep) - cnt_t'(pop);
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers and counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_q[tag_tail_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            q_pc_q[q_tail_q]   <= tag_q[tag_head_q];
            q_data_q[q_tail_q] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= BUBBLE_INST;
            pc_d_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else if (redirect_valid) begin
            instr_q <= BUBBLE_INST;
            valid_q <= 1'b0;
        end else if (!stall_D) begin
            if (q_count_q != '0) begin
                instr_q <= q_data_q[q_head_q];
                pc_d_q  <= q_pc_q[q_head_q];
                valid_q <= 1'b1;
            end else begin
                instr_q <= BUBBLE_INST;
                valid_q <= 1'b0;
            end
        end
    end

endmodule
